ov7670_frame_gen: RTL

Synthesizable OV7670 camera emulator: generates PCLK, VSYNC, HREF and the 8-bit D bus in RGB565 two-bytes-per-pixel format, the same stream a real sensor delivers to the capture block. Pixels come from an internal colour-bar generator or from an external frame-buffer read port. It sits in place of the sensor on the board or in simulation, so the capture → buffer → display path runs without camera hardware.

---
 rtl/ov7670_pkg.sv | 53 +++++
 rtl/ov7670_pixel_src.sv | 42 ++++
 rtl/ov7670_frame_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared constants, colour-bar table, FSM encoding and video payload for the OV7670 emulator.
package ov7670_pkg;

  localparam int unsigned H_ACTIVE_DEF  = 160;
  localparam int unsigned V_ACTIVE_DEF  = 120;
  localparam int unsigned H_BLANK_DEF   = 16;
  localparam int unsigned VSYNC_LEN_DEF = 3;
  localparam int unsigned V_BACK_DEF    = 2;
  localparam int unsigned V_FRONT_DEF   = 2;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [PIX_W-1:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [PIX_W-1:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [PIX_W-1:0] BAR_CYAN    = 16'h07FF;
  localparam logic [PIX_W-1:0] BAR_GREEN   = 16'h07E0;
  localparam logic [PIX_W-1:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [PIX_W-1:0] BAR_RED     = 16'hF800;
  localparam logic [PIX_W-1:0] BAR_BLUE    = 16'h001F;
  localparam logic [PIX_W-1:0] BAR_BLACK   = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_e;

  // Sensor-side video bus driven on each PCLK falling edge
  typedef struct packed {
    logic              vsync;
    logic              href;
    logic [BYTE_W-1:0] d;
  } vid_t;

  // Colour for a bar index, in left-to-right order
  function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_pixel_src.sv
// Pixel source: colour bars from the column index, or memory data held for both bytes.
module ov7670_pixel_src
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned XW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XW-1:0]    x,
  input  logic             mode,
  input  logic             rd_vld,
  input  logic [PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0] pixel_c
);

  localparam int unsigned PW = XW + 3;

  logic [PIX_W-1:0] pix_d, pix_q;
  logic [2:0]       bar_idx;

  // Capture memory data the clk it arrives; byte 1 reads the held copy
  always_comb begin
    pix_d   = rd_vld ? rd_data : pix_q;
    bar_idx = 3'({x, 3'b000} / PW'(H_ACTIVE));
    if (mode) begin
      pixel_c = rd_vld ? rd_data : pix_q;
    end else begin
      pixel_c = bar_colour(bar_idx);
    end
  end

  // Held memory pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

endmodule

// File: rtl/ov7670_frame_gen.sv
// OV7670 sensor emulator: PCLK = clk/2, VSYNC/HREF/D in RGB565, two bytes per pixel.
module ov7670_frame_gen
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned H_BLANK   = H_BLANK_DEF,
  parameter int unsigned VSYNC_LEN = VSYNC_LEN_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              PCLK,
  output logic              VSYNC,
  output logic              HREF,
  output logic [BYTE_W-1:0] D,
  output logic              frame_done
);

  localparam int unsigned LINE_P = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HREF_P = 2 * H_ACTIVE;
  localparam int unsigned HW     = $clog2(LINE_P);
  localparam int unsigned XW     = HW - 1;
  localparam int unsigned YW     = $clog2(VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT);

  state_e            state_d, state_q;
  logic [YW-1:0]     y_d, y_q;
  logic [HW-1:0]     h_d, h_q;
  logic              started_d, started_q;
  logic              mode_d, mode_q;
  logic              pclk_d, pclk_q;
  vid_t              vid_d, vid_q;
  logic              rd_en_d, rd_en_q;
  logic              rd_vld_d, rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [ADDR_W-1:0] addr_cnt_d, addr_cnt_q;
  logic              frame_done_d, frame_done_q;

  state_e            adv_st;
  logic [YW-1:0]     adv_y;
  logic [HW-1:0]     adv_h;
  logic              frame_end_c;
  logic              fetch_next_c;
  logic [PIX_W-1:0]  pixel_c;

  // Number of lines in a state, minus one
  function automatic logic [YW-1:0] line_last(input state_e st);
    case (st)
      ST_VSYNC:  line_last = YW'(VSYNC_LEN - 1);
      ST_VBACK:  line_last = YW'(V_BACK - 1);
      ST_ACTIVE: line_last = YW'(V_ACTIVE - 1);
      ST_VFRONT: line_last = YW'(V_FRONT - 1);
      default:   line_last = '0;
    endcase
  endfunction

  // Position of the PCLK period that starts at the coming falling edge
  always_comb begin
    adv_st      = state_q;
    adv_y       = y_q;
    adv_h       = h_q;
    frame_end_c = 1'b0;
    if (started_q) begin
      if (h_q != HW'(LINE_P - 1)) begin
        adv_h = h_q + HW'(1);
      end else begin
        adv_h = '0;
        if (y_q != line_last(state_q)) begin
          adv_y = y_q + YW'(1);
        end else begin
          adv_y = '0;
          case (state_q)
            ST_VSYNC:  adv_st = ST_VBACK;
            ST_VBACK:  adv_st = ST_ACTIVE;
            ST_ACTIVE: adv_st = ST_VFRONT;
            ST_VFRONT: begin
              frame_end_c = 1'b1;
              adv_st      = enable ? ST_VSYNC : ST_IDLE;
            end
            default:   adv_st = ST_IDLE;
          endcase
        end
      end
    end
  end

  // True when the period after adv_* is byte 0 of a pixel, so its read goes out now
  always_comb begin
    fetch_next_c = 1'b0;
    if (adv_st == ST_ACTIVE && adv_h[0] && adv_h < HW'(HREF_P - 1)) begin
      fetch_next_c = 1'b1;
    end
    if (adv_h == HW'(LINE_P - 1) &&
        ((adv_st == ST_ACTIVE && adv_y != YW'(V_ACTIVE - 1)) ||
         (adv_st == ST_VBACK  && adv_y == YW'(V_BACK - 1)))) begin
      fetch_next_c = 1'b1;
    end
  end

  ov7670_pixel_src #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW)
  ) u_pixel_src (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (adv_h[HW-1:1]),
    .mode    (mode_q),
    .rd_vld  (rd_vld_q),
    .rd_data (rd_data),
    .pixel_c (pixel_c)
  );

  // Frame FSM, PCLK divider, video bus and read-request generation
  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    h_d          = h_q;
    started_d    = started_q;
    mode_d       = mode_q;
    pclk_d       = pclk_q;
    vid_d        = vid_q;
    rd_en_d      = 1'b0;
    rd_vld_d     = rd_en_q;
    rd_addr_d    = rd_addr_q;
    addr_cnt_d   = addr_cnt_q;
    frame_done_d = 1'b0;

    if (state_q == ST_IDLE) begin
      pclk_d = 1'b0;
      vid_d  = '0;
      if (enable) begin
        state_d    = ST_VSYNC;
        y_d        = '0;
        h_d        = '0;
        started_d  = 1'b0;
        mode_d     = mode;
        addr_cnt_d = '0;
      end
    end else begin
      pclk_d = ~pclk_q;
      if (pclk_q) begin
        started_d    = 1'b1;
        state_d      = adv_st;
        y_d          = adv_y;
        h_d          = adv_h;
        frame_done_d = frame_end_c;
        if (frame_end_c) begin
          addr_cnt_d = '0;
          if (enable) begin
            mode_d = mode;
          end
        end
        vid_d.vsync = (adv_st == ST_VSYNC);
        vid_d.href  = (adv_st == ST_ACTIVE) && (adv_h < HW'(HREF_P));
        vid_d.d     = '0;
        if (vid_d.href) begin
          vid_d.d = adv_h[0] ? pixel_c[7:0] : pixel_c[15:8];
        end
        if (mode_q && fetch_next_c) begin
          rd_en_d    = 1'b1;
          rd_addr_d  = addr_cnt_q;
          addr_cnt_d = addr_cnt_q + ADDR_W'(1);
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      y_q          <= '0;
      h_q          <= '0;
      started_q    <= 1'b0;
      mode_q       <= 1'b0;
      pclk_q       <= 1'b0;
      vid_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_addr_q    <= '0;
      addr_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      h_q          <= h_d;
      started_q    <= started_d;
      mode_q       <= mode_d;
      pclk_q       <= pclk_d;
      vid_q        <= vid_d;
      rd_en_q      <= rd_en_d;
      rd_vld_q     <= rd_vld_d;
      rd_addr_q    <= rd_addr_d;
      addr_cnt_q   <= addr_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign PCLK       = pclk_q;
  assign VSYNC      = vid_q.vsync;
  assign HREF       = vid_q.href;
  assign D          = vid_q.d;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign frame_done = frame_done_q;

endmodule
